// File: rtl/tmr_cnt_pkg.sv
// Shared timer definitions: clock-select encodings, count direction and reset value.
package tmr_cnt_pkg;

    localparam logic [1:0] CKS_DIV2  = 2'd0;
    localparam logic [1:0] CKS_DIV4  = 2'd1;
    localparam logic [1:0] CKS_DIV8  = 2'd2;
    localparam logic [1:0] CKS_DIV16 = 2'd3;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    localparam logic [7:0] CNT_RESET_VAL = 8'h00;

    typedef struct packed {
        logic ovf;
        logic udf;
    } wrap_flags_t;

endpackage

// File: rtl/tmr_cnt_if.sv
// Control/data/status bundle between the timer control registers and the counter core.
interface tmr_cnt_if #(parameter int CNT_WIDTH = 8);

    logic                 cnt_load;
    logic [CNT_WIDTH-1:0] cnt_tdr_data;
    logic                 cnt_enable;
    logic                 cnt_up_down;
    logic [1:0]           cnt_cks;
    logic [CNT_WIDTH-1:0] cnt_value;
    logic                 cnt_ovf_flag;
    logic                 cnt_udf_flag;

    modport master (
        output cnt_load, cnt_tdr_data, cnt_enable, cnt_up_down, cnt_cks,
        input  cnt_value, cnt_ovf_flag, cnt_udf_flag
    );

    modport slave (
        input  cnt_load, cnt_tdr_data, cnt_enable, cnt_up_down, cnt_cks,
        output cnt_value, cnt_ovf_flag, cnt_udf_flag
    );

endinterface

// File: rtl/tmr_prescaler.sv
// Free-running clock prescaler; tick fires when the low (cks+1) divider bits are all ones.
module tmr_prescaler #(
    parameter int DIV_WIDTH = 4
) (
    input  logic       cnt_clk,
    input  logic       cnt_reset_n,
    input  logic [1:0] cnt_cks,
    output logic       tick
);

    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] mask;

    always_ff @(posedge cnt_clk or negedge cnt_reset_n) begin
        if (!cnt_reset_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DIV_WIDTH'(1);
        end
    end

    // Bits above the selected divide ratio are forced to one so they never block the tick.
    always_comb begin
        mask = '0;
        for (int i = 0; i < DIV_WIDTH; i++) begin
            mask[i] = (i <= int'(cnt_cks));
        end
    end

    assign tick = &(div_q | ~mask);

endmodule

// File: rtl/tmr_cnt.sv
// Timer counter core: prescaled, loadable up/down counter with one-cycle wrap pulses.
// Define TMR_ONE_SHOT_EN to stop counting after the first wrap until the next load.
import tmr_cnt_pkg::*;

module tmr_cnt #(
    parameter int CNT_WIDTH = 8,
    parameter int DIV_WIDTH = 4
) (
    input  logic    cnt_clk,
    input  logic    cnt_reset_n,
    tmr_cnt_if.slave bus
);

    localparam logic [CNT_WIDTH-1:0] ALL_ONES  = '1;
    localparam logic [CNT_WIDTH-1:0] ALL_ZEROS = '0;
    localparam logic [CNT_WIDTH-1:0] ONE       = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] RESET_VAL = CNT_WIDTH'(CNT_RESET_VAL);

    logic                 tick;
    logic                 count_ok;
    logic                 step;
    logic                 wrap_up;
    logic                 wrap_dn;
    logic [CNT_WIDTH-1:0] count_q;
    wrap_flags_t          flags_q;

    tmr_prescaler #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_prescaler (
        .cnt_clk     (cnt_clk),
        .cnt_reset_n (cnt_reset_n),
        .cnt_cks     (bus.cnt_cks),
        .tick        (tick)
    );

`ifdef TMR_ONE_SHOT_EN
    logic stop_q;

    // Once a wrap has been reported, further ticks are ignored until software reloads.
    always_ff @(posedge cnt_clk or negedge cnt_reset_n) begin
        if (!cnt_reset_n) begin
            stop_q <= 1'b0;
        end else if (bus.cnt_load) begin
            stop_q <= 1'b0;
        end else if (wrap_up || wrap_dn) begin
            stop_q <= 1'b1;
        end
    end

    assign count_ok = ~stop_q;
`else
    assign count_ok = 1'b1;
`endif

    assign step    = !bus.cnt_load && bus.cnt_enable && tick && count_ok;
    assign wrap_up = step && (bus.cnt_up_down == DIR_UP)   && (count_q == ALL_ONES);
    assign wrap_dn = step && (bus.cnt_up_down == DIR_DOWN) && (count_q == ALL_ZEROS);

    // Flags are registered alongside the count so each pulse lines up with the wrapped value.
    always_ff @(posedge cnt_clk or negedge cnt_reset_n) begin
        if (!cnt_reset_n) begin
            count_q <= RESET_VAL;
            flags_q <= '0;
        end else begin
            flags_q.ovf <= wrap_up;
            flags_q.udf <= wrap_dn;
            if (bus.cnt_load) begin
                count_q <= bus.cnt_tdr_data;
            end else if (step) begin
                if (bus.cnt_up_down == DIR_UP) begin
                    count_q <= count_q + ONE;
                end else begin
                    count_q <= count_q - ONE;
                end
            end
        end
    end

    assign bus.cnt_value    = count_q;
    assign bus.cnt_ovf_flag = flags_q.ovf;
    assign bus.cnt_udf_flag = flags_q.udf;

endmodule

// File: tb/tb_tmr_cnt.sv
// Self-checking bench for tmr_cnt: directed plan steps plus random traffic against a cycle model.
`timescale 1ns/1ps
import tmr_cnt_pkg::*;

module tb_tmr_cnt;

    localparam int MAXV = 255;

    logic clk;
    logic rst_n;

    tmr_cnt_if #(.CNT_WIDTH(8)) bus ();

    tmr_cnt #(
        .CNT_WIDTH (8),
        .DIV_WIDTH (4)
    ) dut (
        .cnt_clk     (clk),
        .cnt_reset_n (rst_n),
        .bus         (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int cyc;
    int exp_val;
    int exp_ovf;
    int exp_udf;
    int exp_stop;

`ifdef TMR_ONE_SHOT_EN
    localparam int ONE_SHOT = 1;
`else
    localparam int ONE_SHOT = 0;
`endif

    // Tick period is 2^(cks+1) clocks counted from reset release, the prescaler never resets otherwise.
    function automatic int tickNext(input logic [1:0] cks);
        int period;
        period = 2 << cks;
        return ((cyc % period) == (period - 1)) ? 1 : 0;
    endfunction

    task automatic modelReset();
        cyc      = 0;
        exp_val  = 0;
        exp_ovf  = 0;
        exp_udf  = 0;
        exp_stop = 0;
    endtask

    task automatic modelEdge(input logic ld, input logic [7:0] data, input logic en,
                             input logic ud, input logic [1:0] cks);
        int tk;
        tk = tickNext(cks);
        exp_ovf = 0;
        exp_udf = 0;
        if (ld) begin
            exp_val  = int'(data);
            exp_stop = 0;
        end else if (en && tk == 1 && exp_stop == 0) begin
            if (ud == DIR_UP) begin
                if (exp_val == MAXV) begin
                    exp_ovf  = 1;
                    exp_stop = ONE_SHOT;
                end
                exp_val = (exp_val + 1) % (MAXV + 1);
            end else begin
                if (exp_val == 0) begin
                    exp_udf  = 1;
                    exp_stop = ONE_SHOT;
                end
                exp_val = (exp_val + MAXV) % (MAXV + 1);
            end
        end
        cyc = cyc + 1;
    endtask

    task automatic checkOutput(input string tag);
        checks++;
        assert (int'(bus.cnt_value) === exp_val) else begin
            errors++;
            $error("[TB] FAIL %s value observed %0h expected %0h", tag, bus.cnt_value, exp_val);
        end
        checks++;
        assert (int'(bus.cnt_ovf_flag) === exp_ovf) else begin
            errors++;
            $error("[TB] FAIL %s ovf observed %0b expected %0d", tag, bus.cnt_ovf_flag, exp_ovf);
        end
        checks++;
        assert (int'(bus.cnt_udf_flag) === exp_udf) else begin
            errors++;
            $error("[TB] FAIL %s udf observed %0b expected %0d", tag, bus.cnt_udf_flag, exp_udf);
        end
        checks++;
        assert (!(bus.cnt_ovf_flag === 1'b1 && bus.cnt_udf_flag === 1'b1)) else begin
            errors++;
            $error("[TB] FAIL %s both_flags observed ovf=%0b udf=%0b expected not both",
                   tag, bus.cnt_ovf_flag, bus.cnt_udf_flag);
        end
    endtask

    // Drive one cycle of inputs, clock it, advance the model and compare just after the edge.
    task automatic applyStimulus(input logic ld, input logic [7:0] data, input logic en,
                                 input logic ud, input logic [1:0] cks, input string tag);
        bus.cnt_load     = ld;
        bus.cnt_tdr_data = data;
        bus.cnt_enable   = en;
        bus.cnt_up_down  = ud;
        bus.cnt_cks      = cks;
        modelEdge(ld, data, en, ud, cks);
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        logic       r_ld;
        logic [7:0] r_data;
        logic       r_en;
        logic       r_ud;
        logic [1:0] r_cks;
        int         guard;

        rst_n            = 1'b0;
        bus.cnt_load     = 1'b0;
        bus.cnt_tdr_data = 8'h00;
        bus.cnt_enable   = 1'b0;
        bus.cnt_up_down  = DIR_UP;
        bus.cnt_cks      = CKS_DIV2;
        modelReset();

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_state");
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] count up by 2");
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 8'h00, 1'b1, DIR_UP, CKS_DIV2, "up_div2");

        $display("[TB] overflow from FE");
        applyStimulus(1'b1, 8'hFE, 1'b1, DIR_UP, CKS_DIV2, "load_fe");
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 8'h00, 1'b1, DIR_UP, CKS_DIV2, "ovf_up");

        $display("[TB] underflow from 01 at div16");
        applyStimulus(1'b1, 8'h01, 1'b1, DIR_DOWN, CKS_DIV16, "load_01");
        for (int i = 0; i < 40; i++) applyStimulus(1'b0, 8'h00, 1'b1, DIR_DOWN, CKS_DIV16, "udf_down");

        $display("[TB] load on tick cycle");
        applyStimulus(1'b1, 8'h20, 1'b1, DIR_UP, CKS_DIV4, "load_20");
        guard = 0;
        while (tickNext(CKS_DIV4) == 0 && guard < 20) begin
            applyStimulus(1'b0, 8'h00, 1'b1, DIR_UP, CKS_DIV4, "pre_tick");
            guard++;
        end
        applyStimulus(1'b1, 8'h55, 1'b1, DIR_UP, CKS_DIV4, "load_on_tick");
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'hFF, 1'b1, DIR_UP, CKS_DIV2, "load_held");

        $display("[TB] enable low holds value");
        applyStimulus(1'b1, 8'h10, 1'b1, DIR_UP, CKS_DIV2, "load_10");
        for (int i = 0; i < 40; i++) applyStimulus(1'b0, 8'h00, 1'b0, DIR_UP, CKS_DIV2, "hold_10");
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 8'h00, 1'b1, DIR_UP, CKS_DIV2, "resume");

        $display("[TB] asynchronous reset mid-count");
        applyStimulus(1'b1, 8'hFE, 1'b1, DIR_UP, CKS_DIV2, "load_fe2");
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b1, DIR_UP, CKS_DIV2, "pre_reset");
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput("async_reset");
        @(posedge clk);
        #1;
        checkOutput("reset_held");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'h00, 1'b1, DIR_UP, CKS_DIV2, "post_reset");

        $display("[TB] wrap from FF then idle, reload FF");
        applyStimulus(1'b1, 8'hFF, 1'b1, DIR_UP, CKS_DIV2, "load_ff");
        for (int i = 0; i < 100; i++) applyStimulus(1'b0, 8'h00, 1'b1, DIR_UP, CKS_DIV2, "after_ovf");
        applyStimulus(1'b1, 8'hFF, 1'b1, DIR_UP, CKS_DIV2, "reload_ff");
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 8'h00, 1'b1, DIR_UP, CKS_DIV2, "second_ovf");

        $display("[TB] random traffic");
        r_ud  = DIR_UP;
        r_cks = CKS_DIV2;
        for (int i = 0; i < 500; i++) begin
            r_ld   = ($urandom_range(0, 15) == 0);
            r_data = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00)
                                                 : 8'($urandom);
            r_en   = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) r_ud = ~r_ud;
            if ($urandom_range(0, 31) == 0) r_cks = 2'($urandom);
            applyStimulus(r_ld, r_data, r_en, r_ud, r_cks, "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tmr_cnt.md
Name: tmr_cnt

Overview:
- Timer counter core, directly upstream of the timer status register.
- Produces the one-cycle overflow/underflow pulses consumed by the status register's OVF/UDF set inputs.
- Contains an internal clock prescaler, a loadable up/down counter and wrap detection.
- Driven by control-register fields (load, enable, direction, clock select) and the data-register value.

Parameters:
- CNT_WIDTH, 8, counter and load-data width.
- DIV_WIDTH, 4, prescaler width; supports divide-by 2^1 .. 2^DIV_WIDTH.

Ports:
- cnt_clk  input  1  system clock.
- cnt_reset_n  input  1  asynchronous active-low reset.
- cnt_load  input  1  load request (control-register load bit), level-sensitive.
- cnt_tdr_data  input  CNT_WIDTH  load value from data register.
- cnt_enable  input  1  count enable.
- cnt_up_down  input  1  0 = count up, 1 = count down.
- cnt_cks  input  2  clock select: divide by 2, 4, 8, 16 for values 0..3.
- cnt_value  output  CNT_WIDTH  current count (readable as TCNT).
- cnt_ovf_flag  output  1  one-cycle pulse on up-count wrap.
- cnt_udf_flag  output  1  one-cycle pulse on down-count wrap.

Behaviour:
- Clock and reset: one clock, cnt_clk. Reset is asynchronous, active-low, on cnt_reset_n. Reset clears prescaler, cnt_value, cnt_ovf_flag and cnt_udf_flag to 0. Reset mid-count aborts immediately; no flag is produced.
- Prescaler:
  - Free-running DIV_WIDTH-bit counter, increments every cnt_clk; cleared only by reset.
  - tick is combinational: asserted when the low (cnt_cks+1) prescaler bits are all 1.
  - Resulting tick period is 2, 4, 8 or 16 clocks.
  - cnt_cks change takes effect on the next cycle's tick decode. One shortened or lengthened period at the switch is accepted.
- Counter, in priority order per rising edge:
  - cnt_load=1: cnt_value <= cnt_tdr_data, independent of tick and enable. Both flags 0.
  - Else cnt_enable=1 and tick=1 and cnt_up_down=0: cnt_value <= cnt_value+1, modulo 2^CNT_WIDTH. If old value was all-ones (8'hFF), result is 0 and cnt_ovf_flag <= 1.
  - Else cnt_enable=1 and tick=1 and cnt_up_down=1: cnt_value <= cnt_value-1. If old value was 0, result is all-ones and cnt_udf_flag <= 1.
  - Otherwise hold cnt_value; flags <= 0.
- Flags:
  - Registered, high exactly one cycle, in the same cycle the wrapped value appears on cnt_value.
  - Never both high at once.
- cnt_enable=0: count holds; prescaler keeps running. Re-enable resumes at the next tick; there is no prescaler phase reset.
- Direction change between ticks applies at the next tick. Direction change on the tick cycle uses the new value.
- Load held high: counter keeps reloading every cycle, no counting, no flags.
- Latency: tick edge to updated cnt_value is 1 clock. Load to cnt_value is 1 clock.

Optional Feature:
- Macro TMR_ONE_SHOT_EN.
- Defined:
  - Adds an internal stop bit, cleared by reset and by cnt_load.
  - The stop bit is set in the same edge that produces an OVF or UDF pulse.
  - While the stop bit is set, ticks are ignored and cnt_value holds its wrapped value (0 or all-ones) until the next load.
- Not defined: free-running wrap-around as above; no stop bit exists.

Decomposition:
- Shared timer package holds:
  - CKS encoding constants CKS_DIV2=2'd0, CKS_DIV4=2'd1, CKS_DIV8=2'd2, CKS_DIV16=2'd3.
  - Direction constants DIR_UP=1'b0, DIR_DOWN=1'b1.
  - Counter reset value 8'h00.
- One sub-module: tmr_prescaler (divider counter plus tick decode; inputs cnt_clk, cnt_reset_n, cnt_cks; output tick). The counter and flag logic stay in tmr_cnt.

Test Plan:
- Reset, then cnt_enable=1, cnt_up_down=0, cnt_cks=0 -> cnt_value increments every 2 clocks: 0,1,2...
- Load 8'hFE, count up at cks=0 -> FE, FF, then 00 with cnt_ovf_flag high exactly 1 clock; cnt_udf_flag stays 0.
- Load 8'h01, cnt_up_down=1, cks=3 -> 01, 00, then FF after 16-clock ticks, with a single cnt_udf_flag pulse.
- Assert cnt_load with 8'h55 on a tick cycle while counting -> cnt_value=55 next clock, no increment, no flag.
- Deassert cnt_enable at value 8'h10 for 40 clocks -> value holds 10. Assert cnt_reset_n low mid-count -> value and flags 0 asynchronously.
- TMR_ONE_SHOT_EN defined: load FF, count up -> one ovf pulse, cnt_value stays 00 for 100 clocks. Load 8'hFF again -> next ovf occurs normally.
